// File: rtl/seg_score_display.sv
// seg_score_display: score-to-BCD converter driving a four-digit multiplexed seven-segment display
module seg_score_display #(
  parameter logic [13:0] MAX_SCORE = 14'd9999
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_segclk,
  input  logic        i_blink_clk,
  input  logic        i_blink_en,
  input  logic [13:0] i_score,
  input  logic        i_score_ld,
  output logic        o_busy,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);
  typedef enum logic {IDLE, CONV} state_t;
  state_t      r_state, w_nxt;
  logic        r_seg_q, w_tick, w_done, w_start, w_blank;
  logic [1:0]  r_dig;
  logic [3:0]  r_cnt, w_nib;
  logic [13:0] r_bin;
  logic [15:0] r_bcd, r_disp, w_adj;
  logic [29:0] w_sh;
  logic [3:0]  r_an;
  logic [6:0]  r_seg, w_code;
  assign w_tick  = i_segclk & ~r_seg_q;
  assign w_start = (r_state == IDLE) && i_score_ld;
  assign w_done  = (r_state == CONV) && (r_cnt == 4'd1);
  always_comb begin
    w_nxt = r_state;
    if (w_start) w_nxt = CONV;
    else if (w_done) w_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= IDLE;
    else r_state <= w_nxt;
  for (genvar k = 0; k < 4; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
  end
  assign w_sh = {w_adj, r_bin} << 1;
  // disp is only written on the final shift so the scan never sees a partial result
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_disp <= '0;
    end else if (w_start) begin
      r_bin <= (i_score > MAX_SCORE) ? MAX_SCORE : i_score;
      r_bcd <= '0;
      r_cnt <= 4'd14;
    end else if (r_state == CONV) begin
      r_bcd <= w_sh[29:14];
      r_bin <= w_sh[13:0];
      r_cnt <= r_cnt - 4'd1;
      if (w_done) r_disp <= w_sh[29:14];
    end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_seg_q <= 1'b0;
      r_dig   <= '0;
    end else begin
      r_seg_q <= i_segclk;
      if (w_tick) r_dig <= r_dig + 2'd1;
    end
  assign w_nib   = r_disp[{r_dig, 2'b00} +: 4];
  assign w_blank = (r_dig != 2'd0) && ((r_disp >> {r_dig, 2'b00}) == 16'd0);
  always_comb begin
    w_code = 7'h7F;
    case (w_nib)
      4'd0: w_code = 7'h40;
      4'd1: w_code = 7'h79;
      4'd2: w_code = 7'h24;
      4'd3: w_code = 7'h30;
      4'd4: w_code = 7'h19;
      4'd5: w_code = 7'h12;
      4'd6: w_code = 7'h02;
      4'd7: w_code = 7'h78;
      4'd8: w_code = 7'h00;
      4'd9: w_code = 7'h10;
      default: w_code = 7'h7F;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= (i_blink_en & i_blink_clk) ? 4'hF : ~(4'b0001 << r_dig);
      r_seg <= w_blank ? 7'h7F : w_code;
    end
  assign o_an   = r_an;
  assign o_seg  = r_seg;
  assign o_busy = (r_state == CONV);
  assign o_dp   = 1'b1;
endmodule

// File: tb/tb_seg_score_display.sv
// tb_seg_score_display: directed scoreboard bench for the score display driver
module tb_seg_score_display;
  logic clk = 0, clr, segclk, blink_clk, blink_en, score_ld, busy, dp;
  logic [13:0] score;
  logic [3:0] an;
  logic [6:0] seg;
  int nchk = 0, nbad = 0, mdig = 0, cur = 0, nb;
  logic [10:0] q[$];
  int tbl[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
  int pw[4] = '{1, 10, 100, 1000};

  seg_score_display dut (
    .clk(clk), .clr(clr), .i_segclk(segclk), .i_blink_clk(blink_clk), .i_blink_en(blink_en),
    .i_score(score), .i_score_ld(score_ld), .o_busy(busy), .o_an(an), .o_seg(seg), .o_dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int v, input int d);
    if (d > 0 && v < pw[d]) return 7'h7F;
    return 7'(tbl[(v / pw[d]) % 10]);
  endfunction

  task automatic sb_push();
    logic [3:0] a;
    a = ~(4'b0001 << mdig);
    q.push_back({a, exp_seg(cur, mdig)});
  endtask

  task automatic sb_pop(input string tag);
    logic [10:0] e;
    e = q.pop_front();
    chk({tag, "_an"}, 32'(an), 32'(e[10:7]));
    chk({tag, "_seg"}, 32'(seg), 32'(e[6:0]));
  endtask

  task automatic scan(input string tag);
    mdig = (mdig + 1) % 4;
    sb_push();
    segclk = 1;
    step();
    segclk = 0;
    step();
    sb_pop(tag);
  endtask

  task automatic load(input int v, input string tag);
    score = 14'(v);
    score_ld = 1;
    step();
    score_ld = 0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd14);
    step();
    cur = (v > 9999) ? 9999 : v;
    sb_push();
    sb_pop({tag, "_d0"});
  endtask

  initial begin
    clr = 1; segclk = 0; blink_clk = 0; blink_en = 0; score = 0; score_ld = 0;
    #3;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clr = 0;
    cur = 0;
    mdig = 0;
    sb_push();
    step();
    sb_pop("rel");

    load(1234, "l1234");
    for (int i = 0; i < 4; i++) scan("s1234");

    load(12000, "sat");
    for (int i = 0; i < 4; i++) scan("ssat");

    load(7, "l7");
    for (int i = 0; i < 4; i++) scan("s7");

    load(0, "l0");
    for (int i = 0; i < 4; i++) scan("s0");

    score = 14'd50;
    score_ld = 1;
    step();
    score_ld = 0;
    repeat (4) step();
    chk("ldb_busy_mid", 32'(busy), 32'd1);
    score = 14'd99;
    score_ld = 1;
    step();
    score_ld = 0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      step();
    end
    chk("ldb_busy_rest", 32'(nb), 32'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ldb_no_restart", 32'(busy), 32'd0);
    end
    cur = 50;
    sb_push();
    sb_pop("ldb_d");
    for (int i = 0; i < 4; i++) scan("sldb");

    blink_en = 1;
    blink_clk = 1;
    step();
    chk("blink_on", 32'(an), 32'hF);
    blink_clk = 0;
    sb_push();
    step();
    sb_pop("blink_off");
    blink_en = 0;
    blink_clk = 1;
    sb_push();
    step();
    sb_pop("blink_dis");
    blink_clk = 0;

    score = 14'd4321;
    score_ld = 1;
    step();
    score_ld = 0;
    repeat (6) step();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    clr = 1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_an", 32'(an), 32'hF);
    chk("abort_seg", 32'(seg), 32'h7F);
    chk("abort_dp", 32'(dp), 32'd1);
    @(negedge clk);
    clr = 0;
    mdig = 0;
    cur = 0;
    sb_push();
    step();
    sb_pop("abort_rel");
    for (int i = 0; i < 4; i++) scan("sabort0");
    load(4321, "l4321");
    for (int i = 0; i < 4; i++) scan("s4321");

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
